adder_share_ctrl: RTL and testbench

- Round-robin controller that shares one adder datapath (operands data_width each, sum data_width+1) among NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake and drives the adder's operand registers.
- Waits out the adder latency, captures the sum, and returns it to the owning requester with a valid/ready response.
- Sits between the requester ports (register-file readers, test-bench masters) and the shared adder instance.

---
 rtl/adder_share_pkg.sv | 19 +
 rtl/adder_share_ctrl_rr_pick.sv | 34 +++
 rtl/adder_share_ctrl.sv | 118 +++++++++++
 tb/tb_adder_share_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and sizing helpers for the shared-adder controller.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Tag width for n requesters; a single requester still needs one bit.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int add_latency);
        return (add_latency < 1) ? 1 : $clog2(add_latency + 1);
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any_valid
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before any conditional write,
        // otherwise the unassigned paths infer latches.
        idx         = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_valid = |i_req;
        // Walk from the far end back towards the pointer so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(i_ptr) + k) % N;
            if (i_req[idx]) begin
                o_grant_idx = IDX_W'(idx);
            end
        end
        if (o_any_valid) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one registered-operand adder among NUM_REQ
// requesters, one transaction in flight at a time.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_REQ     = 4,
    parameter  int ADD_LATENCY = 1,
    localparam int TAG_W       = tag_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH:0]           add_sum,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH:0]           rsp_sum,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          busy
);

    localparam int CNT_W = cnt_w(ADD_LATENCY);

    state_t              r_state;
    logic [TAG_W-1:0]    r_owner;
    logic [TAG_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_add_a;
    logic [DATA_WIDTH-1:0] r_add_b;
    logic [DATA_WIDTH:0] r_rsp_sum;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_grant;
    logic [TAG_W-1:0]    w_win;
    logic                w_any;
    logic [TAG_W-1:0]    w_next_ptr;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (TAG_W)
    ) u_rr_pick (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_win),
        .o_any_valid (w_any)
    );

    assign w_next_ptr = (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    // The grant is only an accept while idle; everywhere else it is masked.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_tag   = r_rsp_tag;
    assign busy      = r_busy;

    // NOTE: state registers use non-blocking assignment so every register in
    // this block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_rsp_sum   <= '0;
            r_rsp_tag   <= '0;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_add_a  <= req_a[w_win*DATA_WIDTH +: DATA_WIDTH];
                        r_add_b  <= req_b[w_win*DATA_WIDTH +: DATA_WIDTH];
                        r_owner  <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Adder output is valid ADD_LATENCY edges after the operand update.
                    if (r_cnt == CNT_W'(ADD_LATENCY)) begin
                        r_rsp_sum   <= add_sum;
                        r_rsp_tag   <= r_owner;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the block.
module tb_adder_share_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LAT = 1;
    localparam int TW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [DW-1:0]   add_a;
    logic [DW-1:0]   add_b;
    logic [DW:0]     add_sum;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW:0]     rsp_sum;
    logic [TW-1:0]   rsp_tag;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adder_share_ctrl #(
        .DATA_WIDTH  (DW),
        .NUM_REQ     (N),
        .ADD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    // Shared adder with LAT register stages after the operand registers.
    logic [DW:0] add_pipe [0:7];
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int k = 1; k < 8; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign add_sum = (LAT == 0) ? {1'b0, add_a} + {1'b0, add_b}
                                : add_pipe[(LAT == 0) ? 0 : LAT - 1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Transaction-level model: a transaction accepted in cycle t is in flight
    // for LAT+1 cycles and is offered as a response from cycle t+LAT+2 on.
    bit          m_init  = 0;
    bit          m_idle  = 1;
    int          cyc     = 0;
    int          m_acc   = 0;
    int          m_owner = 0;
    int          m_ptr   = 0;
    int          m_rtag  = 0;
    logic [DW-1:0] m_a   = '0;
    logic [DW-1:0] m_b   = '0;
    logic [DW:0]   m_rsum = '0;
    logic [N-1:0]  g_last = '0;

    always @(negedge clk) begin
        int w;
        bit in_resp;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        w       = winner(req_valid, m_ptr);
        in_resp = !m_idle && (cyc >= m_acc + LAT + 2);
        e_rdy   = (m_idle && w >= 0) ? N'(1) << w : '0;
        e_rv    = in_resp ? N'(1) << m_owner : '0;
        if (m_init) begin
            check("m_req_ready", 32'(req_ready), 32'(e_rdy));
            check("m_busy",      32'(busy),      32'(!m_idle));
            check("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("m_add_a",     32'(add_a),     32'(m_a));
            check("m_add_b",     32'(add_b),     32'(m_b));
            check("m_rsp_sum",   32'(rsp_sum),   32'(m_rsum));
            check("m_rsp_tag",   32'(rsp_tag),   32'(m_rtag));
        end
        g_last = rst ? '0 : req_ready;
        if (rst) begin
            m_init = 1; m_idle = 1; m_owner = 0; m_ptr = 0;
            m_a = '0; m_b = '0; m_rsum = '0; m_rtag = 0;
        end else if (m_idle) begin
            if (w >= 0) begin
                m_idle  = 0;
                m_acc   = cyc;
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_a     = req_a[w*DW +: DW];
                m_b     = req_b[w*DW +: DW];
            end
        end else if (cyc == m_acc + LAT + 1) begin
            m_rsum = {1'b0, m_a} + {1'b0, m_b};
            m_rtag = m_owner;
        end else if (in_resp && rsp_ready[m_owner]) begin
            m_idle = 1;
        end
        cyc++;
    end

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    // Leaves the caller at the negedge of the first response cycle.
    task automatic wait_rsp(input string name);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_idx [5];
        int g_t   [5];
        int ng;
        bit pend [N];

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_add_a",     32'(add_a),     32'd0);
        check("rst_rsp_sum",   32'(rsp_sum),   32'd0);

        // Single request from requester 2.
        next_cycle();
        set_req(2, 8'd7, 8'd9); req_valid = 4'b0100;
        @(negedge clk); check("s_ready_c0", 32'(req_ready), 32'h4);
        next_cycle(); req_valid = '0;
        @(negedge clk);
        check("s_add_a_c1", 32'(add_a), 32'd7);
        check("s_add_b_c1", 32'(add_b), 32'd9);
        next_cycle();
        @(negedge clk); check("s_no_rsp_c2", 32'(rsp_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("s_rsp_valid_c3", 32'(rsp_valid), 32'h4);
        check("s_rsp_sum_c3",   32'(rsp_sum),   32'd16);
        check("s_rsp_tag_c3",   32'(rsp_tag),   32'd2);

        // Maximum operands: the carry must survive into bit DW.
        next_cycle();
        set_req(3, 8'd255, 8'd255); req_valid = 4'b1000;
        @(negedge clk); check("max_ready", 32'(req_ready), 32'h8);
        next_cycle(); req_valid = '0;
        wait_rsp("max");
        check("max_sum",   32'(rsp_sum),   32'd510);
        check("max_carry", 32'(rsp_sum[DW]), 32'd1);
        check("max_tag",   32'(rsp_tag),   32'd3);

        // All requesters valid: strict rotation, fixed spacing.
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, DW'(i + 1), DW'(10 * i));
        req_valid = '1;
        ng = 0;
        for (int t = 0; t < 40 && ng < 5; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g_idx[ng] = i;
                g_t[ng] = t;
                ng++;
            end
        end
        check("rr_count", 32'(ng), 32'd5);
        for (int k = 0; k < ng; k++) begin
            check("rr_order", 32'(g_idx[k]), 32'(k % N));
            if (k > 0) check("rr_spacing", 32'(g_t[k] - g_t[k-1]), 32'(LAT + 3));
        end
        next_cycle(); req_valid = '0;
        wait_idle("rr_drain");

        // Backpressure, then rsp_ready from non-owners only.
        pulse_reset();
        set_req(0, 8'd100, 8'd50); set_req(1, 8'd20, 8'd30); set_req(2, 8'd1, 8'd2);
        req_valid = 4'b0111; rsp_ready = '0;
        @(negedge clk); check("bp_ready", 32'(req_ready), 32'h1);
        next_cycle(); req_valid = 4'b0110;
        wait_rsp("bp");
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            rsp_ready = (k < 5) ? 4'b0000 : 4'b1110;
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_sum",   32'(rsp_sum),   32'd150);
            check("bp_rsp_tag",   32'(rsp_tag),   32'd0);
            check("bp_no_ready",  32'(req_ready), 32'd0);
        end
        next_cycle(); rsp_ready = 4'b0001;
        @(negedge clk); check("bp_release_cycle", 32'(rsp_valid), 32'h1);
        next_cycle(); rsp_ready = '1; req_valid = 4'b0010;
        @(negedge clk);
        check("bp_idle_busy",  32'(busy),      32'd0);
        check("bp_idle_ready", 32'(req_ready), 32'h2);

        // Reset during the second WAIT cycle drops the transaction.
        next_cycle(); req_valid = '0;
        @(negedge clk); check("rw_busy_w1", 32'(busy), 32'd1);
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("rw_busy",  32'(busy),  32'd0);
        check("rw_add_a", 32'(add_a), 32'd0);
        check("rw_add_b", 32'(add_b), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); check("rw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        // Pointer back at 0: requesters 1 and 3 valid must grant 1.
        next_cycle();
        set_req(1, 8'd33, 8'd44); set_req(3, 8'd1, 8'd1); req_valid = 4'b1010;
        @(negedge clk); check("rw_ptr_ready", 32'(req_ready), 32'h2);
        next_cycle(); req_valid = 4'b1000;
        wait_rsp("rw_next");
        check("rw_next_valid", 32'(rsp_valid), 32'h2);
        check("rw_next_sum",   32'(rsp_sum),   32'd77);
        check("rw_next_tag",   32'(rsp_tag),   32'd1);
        next_cycle(); req_valid = '0;
        wait_idle("rw_drain");

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (pend[i] && g_last[i]) begin
                    pend[i] = 0; req_valid[i] = 1'b0;
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 0; req_valid[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    set_req(i, rnd_op(), rnd_op());
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = N'($urandom_range(0, 15));
        end
        next_cycle();
        rst = 1'b0; req_valid = '0; rsp_ready = '1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
